// File: rtl/key_event_fifo_if.sv
// Handshake bundle between the keyboard decoder, the key event FIFO and the game player.
// The upstream pair is a level ready with a one-cycle acknowledge.
// The downstream pair is a level ready with an edge-triggered read_fin.
interface key_event_fifo_if #(
  parameter int DATA_WIDTH = 3
) ();
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_read_fin;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_read_fin;

  // The FIFO side: it accepts events from upstream and presents the head downstream.
  modport slave (
    input  in_ready,
    input  in_data,
    output in_read_fin,
    output out_ready,
    output out_data,
    input  out_read_fin
  );

  // The environment side: the decoder is the producer and the player is the consumer.
  modport master (
    output in_ready,
    output in_data,
    input  in_read_fin,
    input  out_ready,
    input  out_data,
    output out_read_fin
  );
endinterface

// File: rtl/key_event_fifo.sv
// Key event FIFO between Keyboard_Decoder and Game_Player.
// Every held in_ready event is acknowledged once with a one-cycle in_read_fin pulse.
// Events that arrive while the FIFO is full are dropped but still acknowledged.
// A saturating counter records how many events were dropped.
// The head is popped on each rising edge of out_read_fin.
module key_event_fifo #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH),
  parameter int OVF_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  key_event_fifo_if.slave       bus,
  output logic [LOG2_DEPTH:0]   level,
  output logic [OVF_WIDTH-1:0]  overflow_cnt
);

  localparam int LW = LOG2_DEPTH + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    capture;
  logic                    in_read_fin_q;
  logic                    out_read_fin_q;
  logic                    pop_req;
  logic                    do_pop;
  logic                    do_push;
  logic                    drop;
  logic                    full;
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [LOG2_DEPTH-1:0]   rd_ptr;
  logic [LW-1:0]           level_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Upstream handshake state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // S_ACK waits for in_ready to drop, so a held event is not captured twice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_ready)  state_d = S_ACK;
      S_ACK:   if (!bus.in_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture happens on the idle-to-ack transition edge.
  always_comb begin
    capture = 1'b0;
    if (state_q == S_IDLE && bus.in_ready) capture = 1'b1;
  end

  // The acknowledge is a registered copy of capture, so it lasts exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) in_read_fin_q <= 1'b0;
    else          in_read_fin_q <= capture;
  end

  // Rising-edge detector on the consumer acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_read_fin_q <= 1'b0;
    else          out_read_fin_q <= bus.out_read_fin;
  end

  // When the FIFO is full, a same-edge pop frees a slot for the capture.
  // Flush overrides both push and pop.
  always_comb begin
    full    = (level == FULL_LEVEL);
    pop_req = bus.out_read_fin & ~out_read_fin_q;
    do_pop  = pop_req & (level != '0) & ~flush;
    do_push = capture & (~full | do_pop) & ~flush;
    drop    = capture & full & ~do_pop & ~flush;
    level_d = level;
    case ({do_push, do_pop})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      level <= level_d;
    end
  end

  // Storage is cleared on reset, so the head never reads as X.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Dropped-event counter; it holds at all-ones and survives a flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         overflow_cnt <= '0;
    else if (drop && overflow_cnt != '1)  overflow_cnt <= overflow_cnt + OVF_WIDTH'(1);
  end

  assign bus.in_read_fin = in_read_fin_q;
  assign bus.out_ready   = (level != '0);
  assign bus.out_data    = mem[rd_ptr];

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo.
// A fixed vector table covers the single-event, burst/overflow and drain sequences.
// Hand sequences cover full-with-pop, flush, async reset and saturation.
// A randomized phase is checked against a queue-based reference model.
module tb_key_event_fifo;
  localparam int DW    = 3;
  localparam int DEPTH = 8;
  localparam int LD    = $clog2(DEPTH);
  localparam int OW    = 8;

  logic           clock;
  logic           reset_n;
  logic           flush;
  logic [LD:0]    level;
  logic [OW-1:0]  ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  key_event_fifo_if #(.DATA_WIDTH(DW)) bus ();

  key_event_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVF_WIDTH(OW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .bus          (bus),
    .level        (level),
    .overflow_cnt (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: FIFO contents, drop count, and whether the current held event was already taken.
  logic [DW-1:0] mq[$];
  int            m_ovf;
  bit            m_held;
  bit            m_prev_rf;
  bit            m_ack;

  typedef struct {
    logic          ir;
    logic [DW-1:0] id;
    logic          rf;
    logic          fl;
    logic          e_ack;
    logic [LD:0]   e_lvl;
    logic [DW-1:0] e_head;
    logic [OW-1:0] e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf     = 0;
    m_held    = 0;
    m_prev_rf = 0;
    m_ack     = 0;
  endtask

  task automatic model_update(input logic ir, input logic [DW-1:0] id, input logic rf, input logic fl);
    bit cap;
    bit popr;
    cap       = ir && !m_held;
    m_held    = cap ? 1'b1 : (m_held && ir);
    m_ack     = cap;
    popr      = rf && !m_prev_rf;
    m_prev_rf = rf;
    if (fl) begin
      mq.delete();
    end else begin
      if (popr && mq.size() > 0) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(id);
        else if (m_ovf < 255) m_ovf++;
      end
    end
  endtask

  task automatic drive(input logic ir, input logic [DW-1:0] id, input logic rf, input logic fl);
    bus.in_ready     = ir;
    bus.in_data      = id;
    bus.out_read_fin = rf;
    flush            = fl;
    @(posedge clock);
    model_update(ir, id, rf, fl);
    #1;
  endtask

  task automatic model_check();
    chk("ack",   32'(bus.in_read_fin), 32'(m_ack));
    chk("ready", 32'(bus.out_ready),   32'(mq.size() > 0));
    chk("level", 32'(level),           32'(mq.size()));
    chk("ovf",   32'(ovf),             32'(m_ovf));
    if (mq.size() > 0) chk("head", 32'(bus.out_data), 32'(mq[0]));
  endtask

  task automatic step(input logic ir, input logic [DW-1:0] id, input logic rf, input logic fl);
    drive(ir, id, rf, fl);
    model_check();
  endtask

  task automatic add(input logic ir, input logic [DW-1:0] id, input logic rf, input logic fl,
                     input logic e_ack, input int e_lvl, input int e_head, input int e_ovf);
    vec_t v;
    v.ir = ir; v.id = id; v.rf = rf; v.fl = fl;
    v.e_ack  = e_ack;
    v.e_lvl  = (LD+1)'(e_lvl);
    v.e_head = DW'(e_head);
    v.e_ovf  = OW'(e_ovf);
    tbl.push_back(v);
  endtask

  initial begin
    reset_n          = 1'b0;
    flush            = 1'b0;
    bus.in_ready     = 1'b0;
    bus.in_data      = '0;
    bus.out_read_fin = 1'b0;
    model_reset();

    // Vector table: single held event, burst to full plus overflow, drain, held read_fin.
    add(1, 5, 0, 0, 1, 1, 5, 0);
    for (int i = 0; i < 3; i++) add(1, 5, 0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 0, 0, 1, 5, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      add(1, DW'(k), 0, 0, 1, k + 1, 0, 0);
      add(0, 0,      0, 0, 0, k + 1, 0, 0);
    end
    add(1, 6, 0, 0, 1, 8, 0, 1);
    add(0, 0, 0, 0, 0, 8, 0, 1);
    for (int k = 0; k < 8; k++) begin
      add(0, 0, 1, 0, 0, 7 - k, (k + 1) % 8, 1);
      add(0, 0, 0, 0, 0, 7 - k, (k + 1) % 8, 1);
      add(0, 0, 0, 0, 0, 7 - k, (k + 1) % 8, 1);
    end
    add(1, 3, 0, 0, 1, 1, 3, 1);
    add(0, 0, 0, 0, 0, 1, 3, 1);
    add(1, 4, 0, 0, 1, 2, 3, 1);
    add(0, 0, 0, 0, 0, 2, 3, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 1, 4, 1);
    add(0, 0, 0, 0, 0, 1, 4, 1);

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_ack",   32'(bus.in_read_fin), 0);
    chk("rst_ready", 32'(bus.out_ready),   0);
    chk("rst_data",  32'(bus.out_data),    0);
    chk("rst_level", 32'(level),           0);
    chk("rst_ovf",   32'(ovf),             0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (tbl[i]) begin
      drive(tbl[i].ir, tbl[i].id, tbl[i].rf, tbl[i].fl);
      chk($sformatf("vec%0d_ack", i),   32'(bus.in_read_fin), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_ready", i), 32'(bus.out_ready),   32'(tbl[i].e_lvl != 0));
      chk($sformatf("vec%0d_level", i), 32'(level),           32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),             32'(tbl[i].e_ovf));
      if (tbl[i].e_lvl != 0) chk($sformatf("vec%0d_head", i), 32'(bus.out_data), 32'(tbl[i].e_head));
    end

    // Full FIFO: a capture on the same edge as a pop is accepted, not dropped.
    while (mq.size() < DEPTH) begin
      step(1, DW'($urandom), 0, 0);
      step(0, 0, 0, 0);
    end
    step(1, 2, 1, 0);
    chk("fullpop_level", 32'(level), 8);
    chk("fullpop_ovf",   32'(ovf),   1);
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fullpop_last", 32'(bus.out_data), 2);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("fullpop_empty", 32'(bus.out_ready), 0);

    // Flush at level 4 with three drops recorded.
    while (mq.size() < DEPTH) begin
      step(1, DW'($urandom), 0, 0);
      step(0, 0, 0, 0);
    end
    repeat (2) begin
      step(1, 7, 0, 0);
      step(0, 0, 0, 0);
    end
    repeat (4) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("preflush_level", 32'(level), 4);
    chk("preflush_ovf",   32'(ovf),   3);
    step(0, 0, 0, 1);
    chk("flush_ready", 32'(bus.out_ready), 0);
    chk("flush_level", 32'(level),         0);
    chk("flush_ovf",   32'(ovf),           3);
    step(1, 6, 0, 0);
    chk("postflush_head", 32'(bus.out_data), 6);
    step(0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 40,
           $urandom_range(0, 199) == 0);
    end

    // Async reset while the acknowledge is high and in_ready is still held.
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    chk("prerst_ack", 32'(bus.in_read_fin), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ack",   32'(bus.in_read_fin), 0);
    chk("arst_ready", 32'(bus.out_ready),   0);
    chk("arst_level", 32'(level),           0);
    chk("arst_data",  32'(bus.out_data),    0);
    chk("arst_ovf",   32'(ovf),             0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    step(1, 5, 0, 0);
    chk("recap_level", 32'(level), 1);
    chk("recap_ack",   32'(bus.in_read_fin), 1);
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    chk("recap_once", 32'(level), 1);
    step(0, 0, 0, 0);

    // Saturating overflow counter.
    while (mq.size() < DEPTH) begin
      step(1, DW'($urandom), 0, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 300; i++) begin
      step(1, DW'($urandom), 0, 0);
      step(0, 0, 0, 0);
    end
    chk("sat_ovf", 32'(ovf), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
